// File: rtl/register_load_arbiter_if.sv
// Write-request bus between register writers and the shared-register load arbiter.
interface register_load_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data_in;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      reg_in;
   logic                  reg_load;
   logic [2:0]            grant_id;
   logic                  busy;

   modport master (
      output req, data_in,
      input  ack, reg_in, reg_load, grant_id, busy
   );

   modport slave (
      input  req, data_in,
      output ack, reg_in, reg_load, grant_id, busy
   );
endinterface

// File: rtl/register_load_arbiter.sv
// Arbitrates writers onto one shared register: latch winner, pulse LOAD, REQ/ACK.
// Define REG_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module register_load_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input logic clk,
   input logic reset_n,
   register_load_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ACK
   } state_t;

   state_t            state, state_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              load_q, load_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [IW-1:0]     gnt_q, gnt_d;
   logic [WIDTH-1:0]  din [NREQ];
   logic              found;
   logic [IW-1:0]     win;

   for (genvar i = 0; i < NREQ; i++) begin : g_din
      assign din[i] = bus.data_in[i*WIDTH +: WIDTH];
   end

`ifdef REG_ARB_FIXED_PRIORITY_EN
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.req[i]) begin
            found = 1'b1;
            win   = IW'(i);
         end
      end
   end
`else
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] idx;

   // Search starts just past the last winner and wraps.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = IW'((int'(last_q) + off) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign last_d = (state == S_ACK && !bus.req[gnt_q]) ? gnt_q : last_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_q <= IW'(NREQ - 1);
      else          last_q <= last_d;
   end
`endif

   always_comb begin
      state_d = state;
      load_d  = 1'b0;
      ack_d   = '0;
      busy_d  = 1'b0;
      data_d  = data_q;
      gnt_d   = gnt_q;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               state_d = S_LOAD;
               load_d  = 1'b1;
               busy_d  = 1'b1;
               data_d  = din[win];
               gnt_d   = win;
            end
         end
         S_LOAD: begin
            state_d = S_ACK;
            busy_d  = 1'b1;
            ack_d   = ONE << gnt_q;
         end
         S_ACK: begin
            if (bus.req[gnt_q]) begin
               busy_d = 1'b1;
               ack_d  = ONE << gnt_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q  <= '0;
         load_q <= 1'b0;
         busy_q <= 1'b0;
         data_q <= '0;
         gnt_q  <= '0;
      end else begin
         ack_q  <= ack_d;
         load_q <= load_d;
         busy_q <= busy_d;
         data_q <= data_d;
         gnt_q  <= gnt_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.reg_load = load_q;
   assign bus.busy     = busy_q;
   assign bus.reg_in   = data_q;
   assign bus.grant_id = 3'(gnt_q);
endmodule

// File: tb/tb_register_load_arbiter.sv
// Scoreboard bench for register_load_arbiter: expected loads queued at stimulus.
module tb_register_load_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   typedef struct packed {
      logic [2:0]       id;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [WIDTH-1:0] din [NREQ];
   exp_t sb[$];
   exp_t mon_e;
   logic prev_load = 1'b0;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   register_load_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   register_load_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always_comb begin
      bus.data_in = '0;
      for (int i = 0; i < NREQ; i++)
         bus.data_in[i*WIDTH +: WIDTH] = din[i];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.reg_load) begin
         chk("load_width", 32'(prev_load), 0);
         if (sb.size() == 0) begin
            chk("unexpected_load", 32'(bus.reg_load), 0);
         end else begin
            mon_e = sb.pop_front();
            chk("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
            chk("reg_in", 32'(bus.reg_in), 32'(mon_e.data));
         end
      end
      prev_load = bus.reg_load;
   end

   task automatic wait_ack(input int id);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 10) begin
         @(negedge clk);
         if (bus.ack != '0) seen = 1;
         n++;
      end
      if (seen) begin
         chk("ack_onehot", 32'(bus.ack), 32'(1) << id);
         chk("busy_in_ack", 32'(bus.busy), 1);
      end else begin
         chk("ack_timeout", 32'(seen), 1);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      bit seen = 0;
      while (!seen && n < 10) begin
         @(negedge clk);
         if (!bus.busy) seen = 1;
         n++;
      end
      chk("idle_reached", 32'(seen), 1);
      chk("idle_ack", 32'(bus.ack), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   initial begin
      int order [4];
      int cnt;
      int w;

      // reset with all requests pending
      for (int i = 0; i < NREQ; i++) din[i] = 8'(8'h10 + i);
      bus.req = 4'b1111;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_load", 32'(bus.reg_load), 0);
      chk("rst_reg_in", 32'(bus.reg_in), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      sb.push_back('{id: 3'd0, data: din[0]});
      reset_n = 1'b1;
      wait_ack(0);
      bus.req = '0;
      wait_idle();

      // single request, ack held until req drops
      din[2] = 8'h3C;
      @(negedge clk);
      sb.push_back('{id: 3'd2, data: 8'h3C});
      bus.req = 4'b0100;
      wait_ack(2);
      repeat (3) begin
         @(negedge clk);
         chk("ack_hold", 32'(bus.ack), 32'h4);
      end
      bus.req = '0;
      wait_idle();
      chk("single_busy_low", 32'(bus.busy), 0);

      // contention from a fresh reset
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) din[i] = 8'(8'hC0 + i);
`ifdef REG_ARB_FIXED_PRIORITY_EN
      order = '{0, 0, 0, 0};
`else
      order = '{0, 1, 3, 0};
`endif
      for (int n = 0; n < 4; n++) begin
         w = order[n];
         sb.push_back('{id: 3'(w), data: din[w]});
         if (n == 0) bus.req = 4'b1011;
         wait_ack(w);
         @(negedge clk);
         if (n == 3) bus.req = '0;
         else        bus.req[w] = 1'b0;
         wait_idle();
         if (n < 3) bus.req[w] = 1'b1;
      end

      // requester drops during LOAD
      din[1] = 8'hA5;
      @(negedge clk);
      sb.push_back('{id: 3'd1, data: 8'hA5});
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = '0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.ack[1]) cnt++;
      end
      chk("early_ack_cycles", 32'(cnt), 1);
      chk("early_busy_low", 32'(bus.busy), 0);

      // data changes after capture are ignored
      din[0] = 8'h11;
      @(negedge clk);
      sb.push_back('{id: 3'd0, data: 8'h11});
      bus.req = 4'b0001;
      @(negedge clk);
      din[0] = 8'hFF;
      wait_ack(0);
      chk("reg_in_hold", 32'(bus.reg_in), 32'h11);
      bus.req = '0;
      wait_idle();
      chk("reg_in_idle", 32'(bus.reg_in), 32'h11);

      // reset while REG_LOAD is high
      din[2] = 8'h77;
      @(negedge clk);
      bus.req = 4'b0100;
      @(posedge clk);
      #1;
      chk("mid_load_pulse", 32'(bus.reg_load), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_load", 32'(bus.reg_load), 0);
      chk("mid_rst_ack", 32'(bus.ack), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_reg_in", 32'(bus.reg_in), 0);
      chk("mid_rst_grant", 32'(bus.grant_id), 0);
      bus.req = 4'b1000;
      din[3] = 8'h5A;
      @(negedge clk);
      sb.push_back('{id: 3'd3, data: 8'h5A});
      reset_n = 1'b1;
      wait_ack(3);
      bus.req = '0;
      wait_idle();

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
